// File: rtl/pixel_unpacker_pkg.sv
// Shared video definitions for the pixel unpacker: geometry defaults, phase encoding, pixel type.
// No logic; constants and helpers only.
// No flow control here; consumers own their own handshakes.
package pixel_unpacker_pkg;

    localparam int X_SIZE_DEF = 640;
    localparam int Y_SIZE_DEF = 480;

    // Four pixels travel in three 32-bit words.
    localparam int WORDS_PER_LINE_DEF = X_SIZE_DEF * 3 / 4;

    // P0..P2 consume a word each; P3 drains the 24-bit residue without a word.
    typedef enum logic [1:0] {
        P0 = 2'd0,
        P1 = 2'd1,
        P2 = 2'd2,
        P3 = 2'd3
    } phase_e;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb24_t;

    function automatic int words_per_line(input int x_size);
        return x_size * 3 / 4;
    endfunction

    function automatic phase_e phase_next(input phase_e p);
        phase_e n;
        case (p)
            P0:      n = P1;
            P1:      n = P2;
            P2:      n = P3;
            default: n = P0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/pixel_unpacker_core.sv
// Phase FSM, byte residue and the single registered pixel slot of the unpacker.
// Latency: accepted word to pixel valid is 1 cycle; P3 pixel follows on the next free cycle.
// Backpressure: word_rdy_o drops while the slot is full and stalled, and during the P3 drain.
module pixel_unpack_core
    import pixel_unpacker_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        word_vld_i,
    input  logic [31:0] word_dat_i,
    input  logic        word_sof_i,
    input  logic        resync_i,
    input  logic [1:0]  side_i,
    output logic        word_rdy_o,
    output logic        word_take_o,
    output logic        res_emit_o,
    output phase_e      phase_o,
    output logic        locked_o,
    output rgb24_t      pix_dat_o,
    output logic [1:0]  pix_side_o,
    output logic        pix_vld_o,
    input  logic        pix_rdy_i
);

    phase_e      phase_q;
    logic        locked_q;
    logic [23:0] residue_q;
    logic [23:0] residue_d;
    logic [23:0] word_pix;
    rgb24_t      pix_q;
    logic [1:0]  side_q;
    logic        pix_vld_q;
    logic        slot_free;
    phase_e      eff_phase;

    assign slot_free   = !pix_vld_q || pix_rdy_i;
    assign word_rdy_o  = !locked_q || ((phase_q != P3) && slot_free);
    // Unlocked words are swallowed unless they mark a frame start.
    assign word_take_o = word_vld_i && word_rdy_o && (locked_q || word_sof_i);
    assign res_emit_o  = locked_q && (phase_q == P3) && slot_free;
    assign eff_phase   = word_sof_i ? P0 : phase_q;

    assign phase_o    = phase_q;
    assign locked_o   = locked_q;
    assign pix_dat_o  = pix_q;
    assign pix_side_o = side_q;
    assign pix_vld_o  = pix_vld_q;

    // Splice the incoming word with the carried bytes according to the effective phase.
    always_comb begin
        word_pix  = residue_q;
        residue_d = residue_q;
        case (eff_phase)
            P0: begin
                word_pix  = word_dat_i[23:0];
                residue_d = {16'h0, word_dat_i[31:24]};
            end
            P1: begin
                word_pix  = {word_dat_i[15:0], residue_q[7:0]};
                residue_d = {8'h0, word_dat_i[31:16]};
            end
            P2: begin
                word_pix  = {word_dat_i[7:0], residue_q[15:0]};
                residue_d = word_dat_i[31:8];
            end
            default: begin
                word_pix  = residue_q;
                residue_d = residue_q;
            end
        endcase
    end

    // Phase, residue and output slot advance together; a resync returns to P0 with no residue.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            phase_q   <= P0;
            locked_q  <= 1'b0;
            residue_q <= '0;
            pix_q     <= '0;
            side_q    <= '0;
            pix_vld_q <= 1'b0;
        end else if (word_take_o) begin
            pix_q     <= rgb24_t'(word_pix);
            side_q    <= side_i;
            pix_vld_q <= 1'b1;
            locked_q  <= 1'b1;
            if (resync_i) begin
                phase_q   <= P0;
                residue_q <= '0;
            end else begin
                phase_q   <= phase_next(eff_phase);
                residue_q <= residue_d;
            end
        end else if (res_emit_o) begin
            pix_q     <= rgb24_t'(residue_q);
            side_q    <= side_i;
            pix_vld_q <= 1'b1;
            phase_q   <= P0;
            residue_q <= '0;
        end else if (pix_rdy_i) begin
            pix_vld_q <= 1'b0;
        end
    end

endmodule

// File: rtl/pixel_unpacker.sv
// AXI4-Stream 3-words-per-4-pixels unpacker with frame geometry tracking and sticky framing errors.
// Latency: accepted word to pix_valid is 1 cycle; sustains 1 pixel/cycle (3 words per 4 cycles).
// Backpressure: in_stream_tready low during reset, the P3 drain, or when the pixel slot is stalled.
module pixel_unpacker
    import pixel_unpacker_pkg::*;
#(
    parameter int X_SIZE = X_SIZE_DEF,
    parameter int Y_SIZE = Y_SIZE_DEF
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [31:0] in_stream_tdata,
    input  logic [3:0]  in_stream_tkeep,
    input  logic        in_stream_tlast,
    input  logic        in_stream_tuser,
    input  logic        in_stream_tvalid,
    output logic        in_stream_tready,
    output logic [7:0]  pix_r,
    output logic [7:0]  pix_g,
    output logic [7:0]  pix_b,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic        pix_sof,
    output logic        pix_eol,
    output logic        err_tlast_early,
    output logic        err_tlast_missing,
    output logic        err_sof_mid,
    output logic        err_keep,
    input  logic        err_clear,
    output logic [15:0] frame_count
);

    localparam int XW = $clog2(X_SIZE + 1);
    localparam int YW = $clog2(Y_SIZE + 1);
    localparam logic [XW-1:0] X_LAST = XW'(X_SIZE - 1);
    localparam logic [XW-1:0] X_PEN  = XW'(X_SIZE - 2);
    localparam logic [YW-1:0] Y_LAST = YW'(Y_SIZE - 1);

    logic          core_rdy;
    logic          word_take;
    logic          res_emit;
    logic          locked;
    phase_e        phase;
    phase_e        eff_phase;
    rgb24_t        pix_dat;
    logic [1:0]    pix_side;
    logic [1:0]    side;
    logic [XW-1:0] x_q;
    logic [XW-1:0] base_x;
    logic [YW-1:0] y_q;
    logic [YW-1:0] base_y;
    logic [YW-1:0] y_inc;
    logic [15:0]   frame_q;
    logic [3:0]    err_q;
    logic [3:0]    err_set;
    logic          accept;
    logic          exp_last;
    logic          tlast_early;
    logic          tlast_missing;
    logic          sof_mid;

    // Held low while reset is asserted so the stream sees no acceptance during reset.
    assign in_stream_tready = aresetn && core_rdy;
    assign accept           = in_stream_tvalid && in_stream_tready;

    pixel_unpack_core u_core (
        .clk_i       (aclk),
        .rst_ni      (aresetn),
        .word_vld_i  (in_stream_tvalid),
        .word_dat_i  (in_stream_tdata),
        .word_sof_i  (in_stream_tuser),
        .resync_i    (tlast_early),
        .side_i      (side),
        .word_rdy_o  (core_rdy),
        .word_take_o (word_take),
        .res_emit_o  (res_emit),
        .phase_o     (phase),
        .locked_o    (locked),
        .pix_dat_o   (pix_dat),
        .pix_side_o  (pix_side),
        .pix_vld_o   (pix_valid),
        .pix_rdy_i   (pix_ready)
    );

    // Position of the pixel being loaded this cycle; a frame-start word snaps it to the origin
    // before the tlast check so both markers on one word resolve in that order.
    always_comb begin
        eff_phase = in_stream_tuser ? P0 : phase;
        base_x    = x_q;
        base_y    = y_q;
        if (word_take && in_stream_tuser) begin
            base_x = '0;
            base_y = '0;
        end
        y_inc         = (base_y == Y_LAST) ? '0 : base_y + YW'(1);
        side          = {(base_x == '0) && (base_y == '0), base_x == X_LAST};
        exp_last      = (eff_phase == P2) && (base_x == X_PEN);
        tlast_early   = word_take && in_stream_tlast && !exp_last;
        tlast_missing = word_take && !in_stream_tlast && exp_last;
        sof_mid       = word_take && in_stream_tuser && locked &&
                        !((x_q == '0) && (y_q == '0) && (phase == P0));
        err_set       = {tlast_early, tlast_missing, sof_mid,
                         accept && (in_stream_tkeep != 4'hF)};
    end

    // Geometry advances once per pixel loaded into the slot; an early tlast jumps to the next line.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            x_q     <= '0;
            y_q     <= '0;
            frame_q <= '0;
        end else if (word_take || res_emit) begin
            if (tlast_early) begin
                x_q <= '0;
                y_q <= y_inc;
            end else if (base_x == X_LAST) begin
                x_q <= '0;
                y_q <= y_inc;
                if (base_y == Y_LAST) begin
                    frame_q <= frame_q + 16'd1;
                end
            end else begin
                x_q <= base_x + XW'(1);
                y_q <= base_y;
            end
        end
    end

    // Sticky error flags; a clear in the same cycle as a new event wins.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            err_q <= '0;
        end else if (err_clear) begin
            err_q <= '0;
        end else begin
            err_q <= err_q | err_set;
        end
    end

    assign pix_r             = pix_dat.r;
    assign pix_g             = pix_dat.g;
    assign pix_b             = pix_dat.b;
    assign pix_sof           = pix_side[1];
    assign pix_eol           = pix_side[0];
    assign err_tlast_early   = err_q[3];
    assign err_tlast_missing = err_q[2];
    assign err_sof_mid       = err_q[1];
    assign err_keep          = err_q[0];
    assign frame_count       = frame_q;

endmodule

// File: tb/tb_pixel_unpacker.sv
// Bench for pixel_unpacker at an 8x2 frame: byte-stream reference model plus directed literal checks.
// Inputs change 1ns after the rising edge; everything is sampled on the falling edge.
// Ready is either held, randomised, or driven by hand depending on the test phase.
module tb_pixel_unpacker;

    localparam int XS  = 8;
    localparam int YS  = 2;
    localparam int WPL = XS * 3 / 4;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [31:0] tdata = '0;
    logic [3:0]  tkeep = 4'hF;
    logic        tlast = 1'b0;
    logic        tuser = 1'b0;
    logic        tvalid = 1'b0;
    logic        tready;
    logic [7:0]  pr, pg, pb;
    logic        pv, psof, peol;
    logic        prdy = 1'b1;
    logic        e_early, e_miss, e_sof, e_keep;
    logic        eclr = 1'b0;
    logic [15:0] fcnt;

    int n_checks = 0;
    int n_fail   = 0;
    int rdy_mode = 2;

    // Reference model state: a byte FIFO of received stream bytes, pixel position, word-in-line.
    bit          m_locked;
    logic [7:0]  m_buf[$];
    int          m_x, m_y, m_wi, m_frames;
    logic [3:0]  m_err, m_set;
    logic [25:0] exp_q[$];
    logic [25:0] log_q[$];
    bit          held;
    logic [25:0] held_val;

    always #5 aclk = ~aclk;

    pixel_unpacker #(.X_SIZE(XS), .Y_SIZE(YS)) dut (
        .aclk              (aclk),
        .aresetn           (aresetn),
        .in_stream_tdata   (tdata),
        .in_stream_tkeep   (tkeep),
        .in_stream_tlast   (tlast),
        .in_stream_tuser   (tuser),
        .in_stream_tvalid  (tvalid),
        .in_stream_tready  (tready),
        .pix_r             (pr),
        .pix_g             (pg),
        .pix_b             (pb),
        .pix_valid         (pv),
        .pix_ready         (prdy),
        .pix_sof           (psof),
        .pix_eol           (peol),
        .err_tlast_early   (e_early),
        .err_tlast_missing (e_miss),
        .err_sof_mid       (e_sof),
        .err_keep          (e_keep),
        .err_clear         (eclr),
        .frame_count       (fcnt)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    task automatic m_reset();
        m_locked = 0;
        m_buf.delete();
        m_x = 0; m_y = 0; m_wi = 0; m_frames = 0;
        m_err = '0;
        exp_q.delete();
    endtask

    // Take three bytes off the stream, lowest first -> blue, green, red.
    task automatic m_pop_pixel();
        logic [23:0] p;
        p[7:0]   = m_buf.pop_front();
        p[15:8]  = m_buf.pop_front();
        p[23:16] = m_buf.pop_front();
        exp_q.push_back({p, m_x == 0 && m_y == 0, m_x == XS - 1});
        if (m_x == XS - 1) begin
            m_x  = 0;
            m_wi = 0;
            if (m_y == YS - 1) begin
                m_y = 0;
                m_frames++;
            end else begin
                m_y++;
            end
        end else begin
            m_x++;
        end
    endtask

    task automatic m_word(input logic [31:0] d, input bit u, input bit l, input logic [3:0] k);
        bit exp_last;
        if (k != 4'hF) m_set[0] = 1'b1;
        if (!m_locked && !u) return;
        if (u) begin
            if (m_locked && !(m_x == 0 && m_y == 0 && m_buf.size() == 0)) m_set[1] = 1'b1;
            m_buf.delete();
            m_x = 0; m_y = 0; m_wi = 0;
            m_locked = 1;
        end
        for (int i = 0; i < 4; i++) m_buf.push_back(d[8*i +: 8]);
        exp_last = (m_wi == WPL - 1);
        m_pop_pixel();
        if (l && !exp_last) begin
            m_set[3] = 1'b1;
            m_buf.delete();
            m_x  = 0;
            m_y  = (m_y + 1) % YS;
            m_wi = 0;
        end else begin
            if (!l && exp_last) m_set[2] = 1'b1;
            m_wi++;
            if (m_buf.size() >= 3) m_pop_pixel();
        end
    endtask

    // Per-cycle comparison against the model; the handshake seen now takes effect at the next edge.
    always @(negedge aclk) begin
        if (!aresetn) begin
            m_reset();
            held = 0;
        end else begin
            check("err_flags", {e_early, e_miss, e_sof, e_keep}, m_err);
            if (!m_locked) check("tready_unlocked", tready, 1);
            if (held) check("stall_hold", {pv, pr, pg, pb, psof, peol}, {1'b1, held_val});
            if (pv && prdy) begin
                log_q.push_back({pr, pg, pb, psof, peol});
                if (exp_q.size() == 0) fail_now("unexpected_pixel");
                else check("pixel", {pr, pg, pb, psof, peol}, exp_q.pop_front());
            end
            held     = pv && !prdy;
            held_val = {pr, pg, pb, psof, peol};
            m_set    = '0;
            if (tvalid && tready) m_word(tdata, tuser, tlast, tkeep);
            m_err = eclr ? 4'h0 : (m_err | m_set);
        end
    end

    // Downstream ready driver: 0 = always ready, 1 = random, 2 = manual.
    initial begin
        forever begin
            @(posedge aclk);
            #1;
            if (rdy_mode == 0) prdy = 1'b1;
            else if (rdy_mode == 1) prdy = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic send_word(input logic [31:0] d, input bit u, input bit l,
                             input logic [3:0] k, output int waits);
        bit acc;
        tdata = d; tuser = u; tlast = l; tkeep = k; tvalid = 1'b1;
        waits = 0;
        acc   = 0;
        while (!acc && waits <= 100) begin
            @(negedge aclk);
            acc = tready;
            @(posedge aclk);
            #1;
            if (!acc) waits++;
        end
        if (!acc) fail_now("send_word_timeout");
        tvalid = 1'b0; tuser = 1'b0; tlast = 1'b0; tkeep = 4'hF;
    endtask

    task automatic send_line(input int nw, input int uw, input int lw, input int kw, input int gap);
        int w8;
        for (int w = 0; w < nw; w++) begin
            send_word($urandom, w == uw, w == lw,
                      (w == kw) ? 4'($urandom_range(0, 14)) : 4'hF, w8);
            if (gap > 0) begin
                repeat ($urandom_range(0, gap)) begin
                    @(posedge aclk);
                    #1;
                end
            end
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || pv) && n < 300) begin
            @(posedge aclk);
            #1;
            n++;
        end
        if (n >= 300) fail_now("drain_timeout");
        repeat (2) @(posedge aclk);
        #1;
    endtask

    task automatic do_reset();
        tvalid = 1'b0;
        @(posedge aclk);
        #3;
        aresetn = 1'b0;
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        log_q.delete();
    endtask

    int w;
    int eol_cnt;

    initial begin
        // Reset state while aresetn is held low.
        repeat (3) @(posedge aclk);
        #1;
        check("rst_tready", tready, 0);
        check("rst_outputs", {pv, pr, pg, pb, psof, peol, e_early, e_miss, e_sof, e_keep, fcnt}, 0);
        aresetn = 1'b1;
        #1;
        check("tready_after_rst", tready, 1);

        // Test 1: basic unpack of one 4-pixel group.
        rdy_mode = 0;
        send_word(32'h44332211, 1, 0, 4'hF, w);
        check("t1_latency", {pv, pr, pg, pb, psof}, {1'b1, 24'h332211, 1'b1});
        send_word(32'h88776655, 0, 0, 4'hF, w);
        send_word(32'hCCBBAA99, 0, 0, 4'hF, w);
        check("t1_tready_p3", tready, 0);
        wait_drain();
        check("t1_count", log_q.size(), 4);
        if (log_q.size() == 4) begin
            check("t1_p0", log_q[0], {24'h332211, 2'b10});
            check("t1_p1", log_q[1], {24'h665544, 2'b00});
            check("t1_p2", log_q[2], {24'h998877, 2'b00});
            check("t1_p3", log_q[3], {24'hCCBBAA, 2'b00});
        end

        // Test 2: words before the first frame start are dropped.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            send_word($urandom, 0, i == 1, 4'hF, w);
            check("t2_junk_waits", w, 0);
        end
        @(posedge aclk);
        #1;
        check("t2_no_pixel", pv, 0);
        send_word(32'h00ABCDEF, 1, 0, 4'hF, w);
        wait_drain();
        check("t2_count", log_q.size(), 1);
        if (log_q.size() >= 1) check("t2_sof_pixel", log_q[0], {24'hABCDEF, 2'b10});

        // Test 3: five-cycle stall mid-line.
        do_reset();
        rdy_mode = 2;
        prdy     = 1'b1;
        fork
            send_line(WPL, 0, WPL - 1, -1, 0);
            begin
                repeat (3) @(posedge aclk);
                #1;
                prdy = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    @(negedge aclk);
                    check("t3_stall_tready", tready, 0);
                    check("t3_stall_valid", pv, 1);
                end
                @(posedge aclk);
                #1;
                prdy = 1'b1;
            end
        join
        wait_drain();
        check("t3_count", log_q.size(), XS);

        // Test 4: one complete frame.
        do_reset();
        rdy_mode = 0;
        send_line(WPL, 0, WPL - 1, -1, 0);
        send_line(WPL, -1, WPL - 1, -1, 0);
        wait_drain();
        check("t4_count", log_q.size(), 2 * XS);
        eol_cnt = 0;
        foreach (log_q[i]) eol_cnt += int'(log_q[i][0]);
        check("t4_eol_count", eol_cnt, 2);
        if (log_q.size() == 2 * XS) begin
            check("t4_sof", log_q[0][1], 1);
            check("t4_eol_a", log_q[XS - 1][0], 1);
            check("t4_eol_b", log_q[2 * XS - 1][0], 1);
        end
        check("t4_frame_count", fcnt, 1);
        check("t4_flags", {e_early, e_miss, e_sof, e_keep}, 0);

        // Test 5: early tlast on word 3, then a full line, then clear.
        do_reset();
        send_line(3, 0, 2, -1, 0);
        wait_drain();
        check("t5_early_set", e_early, 1);
        send_line(WPL, -1, WPL - 1, -1, 0);
        wait_drain();
        check("t5_count", log_q.size(), 3 + XS);
        if (log_q.size() == 3 + XS) begin
            check("t5_cut_no_eol", log_q[2][0], 0);
            check("t5_newline_no_sof", log_q[3][1], 0);
            check("t5_eol", log_q[3 + XS - 1][0], 1);
        end
        check("t5_frame_count", fcnt, 1);
        eclr = 1'b1;
        @(posedge aclk);
        #1;
        eclr = 1'b0;
        check("t5_cleared", e_early, 0);

        // Test 6: frame start on word 2, then reset mid-word.
        do_reset();
        send_word(32'h03020100, 1, 0, 4'hF, w);
        send_word(32'h77665544, 1, 0, 4'hF, w);
        wait_drain();
        check("t6_sof_mid", e_sof, 1);
        check("t6_count", log_q.size(), 2);
        if (log_q.size() == 2) check("t6_resync_pixel", log_q[1], {24'h665544, 2'b10});
        send_word(32'hDEADBEEF, 0, 0, 4'hF, w);
        tvalid = 1'b1;
        tdata  = 32'h12345678;
        #3;
        aresetn = 1'b0;
        #1;
        check("t6_async_rst", {tready, pv, pr, pg, pb, psof, peol,
                               e_early, e_miss, e_sof, e_keep, fcnt}, 0);
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        tvalid  = 1'b0;
        log_q.delete();
        send_word(32'h11223344, 0, 0, 4'hF, w);
        check("t6_unlocked_waits", w, 0);
        repeat (2) @(posedge aclk);
        #1;
        check("t6_unlocked_no_pixel", pv, 0);

        // Randomised traffic with occasional framing faults and clears.
        do_reset();
        rdy_mode = 1;
        send_line(2, -1, -1, -1, 1);
        for (int ln = 0; ln < 40; ln++) begin
            int r, uw, lw, kw;
            r  = $urandom_range(0, 15);
            uw = (ln % 2 == 0) ? 0 : -1;
            lw = WPL - 1;
            kw = -1;
            if (r == 0) lw = $urandom_range(0, WPL - 2);
            if (r == 1) lw = -1;
            if (r == 2) uw = $urandom_range(1, WPL - 1);
            if (r == 3) kw = $urandom_range(0, WPL - 1);
            if (r == 4) begin
                eclr = 1'b1;
                @(posedge aclk);
                #1;
                eclr = 1'b0;
            end
            send_line(WPL, uw, lw, kw, 2);
        end
        wait_drain();
        check("rand_frame_count", fcnt, 16'(m_frames));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
